counter_seq_ctrl: RTL and testbench
===================================

# counter_seq_ctrl

Command sequencer and two-port round-robin arbiter for the 4-bit mod-12 up/down counter, which counts every cycle unless loaded. Two requesters submit LOAD, STEP or SEEK commands. The block executes one command at a time by driving the counter's load, din and up_down inputs, and holds the counter between commands by reloading its current value. It sits between the control agents and the counter instance, and shares the counter's clock and reset.

## Interface
Parameters:
- none (the counter range 0..11 is fixed)

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low; shared with the counter
- req_valid  in  2  per-requester command valid (bit 0 = A, bit 1 = B)
- req_ready  out  2  per-requester accept; combinational, high only in IDLE for the arbitration winner
- req_op  in  4  {B[1:0], A[1:0]}; 00 LOAD, 01 STEP, 10 SEEK, 11 reserved
- req_arg  in  8  {B[3:0], A[3:0]}; load value, step count or seek target
- req_dir  in  2  STEP direction per requester; 0 up, 1 down (matches counter up_down)
- count  in  4  counter output
- ctr_load  out  1  counter load
- ctr_din  out  4  counter load data
- ctr_up_down  out  1  counter direction
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester of the completed command; valid with done
- err  out  1  one-cycle pulse with done when the command was reserved or its arg was clamped

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Drives ctr_load=1, ctr_din=count (hold).
  - If any req_valid is set, req_ready goes high for the winner; acceptance happens when valid and ready are both high.
  - The opcode, clamped arg, direction, remaining-step count and requester id are latched.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last time wins.
  - The last-grant register resets to B, so A wins the first tie.
- LOAD:
  - Arg greater than 11 is clamped to 11 and err is flagged.
  - Drives ctr_load=1, ctr_din=arg for one cycle, then goes to DONE.
- STEP:
  - rem = arg; arg greater than 11 is allowed, so up to 15 steps.
  - If rem=0, goes directly to DONE.
  - Otherwise goes to RUN with ctr_load=0 and ctr_up_down=dir.
- SEEK:
  - A target greater than 11 is clamped to 11 and err is flagged.
  - Distances at accept: up = (target − count) mod 12, down = (count − target) mod 12.
  - Choose up if up ≤ down, else down; rem = the chosen distance.
  - If count is greater than 11, use up with rem = target+1. The counter wraps from ≥11 to 0.
  - If rem=0, goes directly to DONE.
- RUN:
  - ctr_load=0, ctr_up_down = latched dir.
  - rem decrements every cycle; when rem=1, goes to DONE.
- Reserved op: goes directly to DONE with err=1; the counter is held.
- DONE:
  - done=1, done_id = latched id; hold drive as in IDLE; then returns to IDLE.
- Requests presented while busy are not accepted. req_valid must stay asserted until req_ready is seen.
- The wrap behaviour during RUN is the counter's own: up from 11 goes to 0, down from 0 goes to 11.

## Timing
- Cycle 0 is the accept cycle (IDLE, handshake).
- LOAD: cycle 1 is LOAD and count equals arg after that edge. Cycle 2 is DONE. Cycle 3 is IDLE.
- STEP/SEEK with rem=N≥1: cycles 1..N are RUN and count changes at the end of each. Cycle N+1 is DONE.
- rem=0 or reserved op: cycle 1 is DONE.
- Earliest next accept is the cycle after DONE, so there is no back-to-back acceptance.
- Reset:
  - Any cycle with resetn=0 forces IDLE, busy=0, done=0, err=0, req_ready=0, ctr_load=1 and ctr_din=count, and sets last-grant to B.
  - An in-flight command is aborted with no done pulse.
- All outputs are Moore outputs decoded from registered state, except req_ready, which is combinational from req_valid.

## Test plan
- Reset, then A: LOAD 7 -> req_ready[0] in cycle 0, count=7 after cycle 1, done=1 and done_id=0 in cycle 2; count stays 7 for the next 10 idle cycles.
- Count=10, A: STEP 4 up -> count sequence 11, 0, 1, 2; done in cycle 5; err=0.
- Count=1, B: SEEK 10 -> down path (distance 3 vs up 9); count 0, 11, 10; done_id=1.
- Count=5: SEEK 11 -> up path (distance 6 each way, tie goes up), final count 11. SEEK 14 -> clamped to 11, err=1. LOAD 13 -> count=11, err=1.
- A and B valid together three times in a row -> grants A, B, A; each done_id matches; the waiting requester's req_ready stays low until the cycle after DONE.
- resetn low mid-RUN of STEP 9 -> next cycle busy=0, no done pulse, count=0. STEP 0 and op 11 -> done in cycle 1, with err=1 for op 11 only.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Command sequencer and two-port round-robin arbiter in front of a 4-bit
// mod-12 up/down counter. The counter counts every cycle unless loaded. This
// block keeps the counter still between commands by reloading its own value.
// It runs one LOAD, STEP or SEEK command at a time.
//
// Ports
//   clk, resetn      clock; synchronous active-low reset shared with the counter
//   req_valid[1:0]   command valid per requester (bit 0 = A, bit 1 = B)
//   req_ready[1:0]   accept, combinational, only in IDLE and only for the winner
//   req_op[3:0]      {B,A} opcode: 00 LOAD, 01 STEP, 10 SEEK, 11 reserved
//   req_arg[7:0]     {B,A} load value / step count / seek target
//   req_dir[1:0]     {B,A} STEP direction, 0 up, 1 down
//   count[3:0]       counter output
//   ctr_load, ctr_din, ctr_up_down   counter controls
//   busy             high whenever the FSM is not in IDLE
//   done, done_id    one-cycle completion pulse and the requester it belongs to
//   err              with done: reserved opcode, or the argument was clamped
//
// Handshake: a requester holds req_valid (with op/arg/dir stable) until it sees
// req_ready. The command transfers on the rising edge where both are high.
// While busy, req_ready stays low, so requests are never accepted back-to-back.
module counter_seq_ctrl (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_arg,
  input  logic [1:0] req_dir,
  input  logic [3:0] count,
  output logic       ctr_load,
  output logic [3:0] ctr_din,
  output logic       ctr_up_down,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'd11;

  state_t     state_q, state_d;
  logic [3:0] arg_q, arg_d;
  logic [3:0] rem_q, rem_d;
  logic       dir_q, dir_d;
  logic       id_q, id_d;
  logic       err_q, err_d;
  logic       last_q, last_d;   // requester granted last time (0 = A, 1 = B)

  // Arbitration and selection of the winning command.
  logic       any_valid;
  logic       win;
  logic [1:0] sel_op;
  logic [3:0] sel_arg;
  logic       sel_dir;
  logic [3:0] tgt;
  logic       clamped;
  logic [4:0] up_dist, dn_dist;
  logic [3:0] seek_rem;
  logic       seek_dir;

  always_comb begin
    any_valid = |req_valid;
    case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;     // on a tie, the one not served last time
      default: win = 1'b0;
    endcase
    sel_op  = win ? req_op[3:2]  : req_op[1:0];
    sel_arg = win ? req_arg[7:4] : req_arg[3:0];
    sel_dir = win ? req_dir[1]   : req_dir[0];
    clamped = (sel_arg > MAX_CNT);
    tgt     = clamped ? MAX_CNT : sel_arg;
  end

  // SEEK distance both ways round the 12-value ring. Ties go up.
  // An out-of-range count wraps to 0 on the next up step, so in that case
  // the path is always up with target+1 steps.
  always_comb begin
    if (tgt >= count) up_dist = {1'b0, tgt} - {1'b0, count};
    else              up_dist = {1'b0, tgt} + 5'd12 - {1'b0, count};
    if (count >= tgt) dn_dist = {1'b0, count} - {1'b0, tgt};
    else              dn_dist = {1'b0, count} + 5'd12 - {1'b0, tgt};

    if (count > MAX_CNT) begin
      seek_dir = 1'b0;
      seek_rem = tgt + 4'd1;
    end else if (up_dist <= dn_dist) begin
      seek_dir = 1'b0;
      seek_rem = up_dist[3:0];
    end else begin
      seek_dir = 1'b1;
      seek_rem = dn_dist[3:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    arg_d   = arg_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    id_d    = id_q;
    err_d   = err_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          id_d   = win;
          last_d = win;
          case (sel_op)
            2'b00: begin
              arg_d   = tgt;
              err_d   = clamped;
              state_d = S_LOAD;
            end
            2'b01: begin
              rem_d   = sel_arg;   // up to 15 steps; wrap is the counter's job
              dir_d   = sel_dir;
              err_d   = 1'b0;
              state_d = (sel_arg == 4'd0) ? S_DONE : S_RUN;
            end
            2'b10: begin
              rem_d   = seek_rem;
              dir_d   = seek_dir;
              err_d   = clamped;
              state_d = (seek_rem == 4'd0) ? S_DONE : S_RUN;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_LOAD: state_d = S_DONE;
      S_RUN: begin
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      arg_q   <= 4'd0;
      rem_q   <= 4'd0;
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  // Outputs. While resetn is low, everything is forced to the idle/hold
  // values even if the registered state has not yet returned to IDLE.
  always_comb begin
    req_ready   = 2'b00;
    ctr_load    = 1'b1;
    ctr_din     = count;
    ctr_up_down = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    done_id     = id_q;
    err         = 1'b0;
    if (resetn) begin
      busy = (state_q != S_IDLE);
      case (state_q)
        S_IDLE: if (any_valid) req_ready = win ? 2'b10 : 2'b01;
        S_LOAD: ctr_din = arg_q;
        S_RUN: begin
          ctr_load    = 1'b0;
          ctr_up_down = dir_q;
        end
        S_DONE: begin
          done = 1'b1;
          err  = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  localparam int W = 22;  // {done_cycle[15:0], id, err, final_count[3:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req_valid = 2'b00;
  logic [3:0] req_op    = 4'd0;
  logic [7:0] req_arg   = 8'd0;
  logic [1:0] req_dir   = 2'b00;
  logic [3:0] count     = 4'd0;
  logic [1:0] req_ready;
  logic       ctr_load, ctr_up_down, busy, done, done_id, err;
  logic [3:0] ctr_din;

  counter_seq_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_arg(req_arg), .req_dir(req_dir),
    .count(count),
    .ctr_load(ctr_load), .ctr_din(ctr_din), .ctr_up_down(ctr_up_down),
    .busy(busy), .done(done), .done_id(done_id), .err(err)
  );

  // Mod-12 up/down counter that the sequencer drives.
  always @(posedge clk) begin
    if (!resetn)          count <= 4'd0;
    else if (ctr_load)    count <= ctr_din;
    else if (ctr_up_down) count <= (count == 4'd0 || count > 4'd11) ? 4'd11 : count - 4'd1;
    else                  count <= (count >= 4'd11) ? 4'd0 : count + 4'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mod12(input int v);
    return ((v % 12) + 12) % 12;
  endfunction

  // Shortest walk round the ring; ties go up.
  function automatic int seek_steps(input int c, input int t, output logic d);
    int up, dn;
    up = 0; dn = 0;
    for (int k = 11; k >= 0; k--) if (mod12(c + k) == t) up = k;
    for (int k = 11; k >= 0; k--) if (mod12(c - k) == t) dn = k;
    if (up <= dn) begin d = 1'b0; return up; end
    d = 1'b1;
    return dn;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int   busy_until = -1;
  int   run_until  = -1;
  int   load_cyc   = -1;
  int   acc_cyc    = -1;
  logic last_g     = 1'b1;
  logic cur_dir    = 1'b0;
  logic [3:0] cur_load_val = 4'd0;

  logic       exp_idle, m_w, m_dir, m_err;
  logic [1:0] exp_ready, m_op;
  int         m_arg, m_clamp, m_fin, m_steps, m_lat, m_c;

  // Stimulus-side observer: sees every handshake, predicts the response.
  always @(negedge clk) begin
    if (!resetn) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_ready", req_ready, 0);
      check("rst_load", ctr_load, 1);
      check("rst_din", ctr_din, count);
      exp_q.delete();
      busy_until = cyc;
      run_until  = -1;
      load_cyc   = -1;
      last_g     = 1'b1;
    end else begin
      exp_idle = (cyc > busy_until);
      check("busy", busy, !exp_idle);

      case (req_valid)
        2'b01:   m_w = 1'b0;
        2'b10:   m_w = 1'b1;
        default: m_w = ~last_g;
      endcase
      exp_ready = (exp_idle && req_valid != 2'b00) ? (m_w ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", req_ready, exp_ready);

      if (cyc > acc_cyc && cyc <= run_until) begin
        check("run_load", ctr_load, 0);
        check("run_dir", ctr_up_down, cur_dir);
      end else if (cyc == load_cyc) begin
        check("load_load", ctr_load, 1);
        check("load_din", ctr_din, cur_load_val);
      end else begin
        check("hold_load", ctr_load, 1);
        check("hold_din", ctr_din, count);
      end

      if (exp_idle && req_valid != 2'b00) begin
        m_op    = m_w ? req_op[3:2] : req_op[1:0];
        m_arg   = int'(m_w ? req_arg[7:4] : req_arg[3:0]);
        m_dir   = m_w ? req_dir[1] : req_dir[0];
        m_clamp = (m_arg > 11) ? 11 : m_arg;
        m_c     = int'(count);
        run_until = -1;
        load_cyc  = -1;
        case (m_op)
          2'd0: begin
            m_fin = m_clamp; m_err = (m_arg > 11); m_lat = 2;
            load_cyc = cyc + 1; cur_load_val = 4'(m_clamp);
          end
          2'd1, 2'd2: begin
            if (m_op == 2'd1) begin
              m_steps = m_arg;
              m_fin   = m_dir ? mod12(m_c - m_arg) : mod12(m_c + m_arg);
              m_err   = 1'b0;
            end else begin
              m_steps = seek_steps(m_c, m_clamp, m_dir);
              m_fin   = m_clamp;
              m_err   = (m_arg > 11);
            end
            m_lat     = (m_steps == 0) ? 1 : m_steps + 1;
            run_until = cyc + m_steps;
            cur_dir   = m_dir;
          end
          default: begin
            m_fin = m_c; m_err = 1'b1; m_lat = 1;
          end
        endcase
        acc_cyc    = cyc;
        busy_until = cyc + m_lat;
        last_g     = m_w;
        exp_q.push_back({16'(cyc + m_lat), m_w, m_err, 4'(m_fin)});
      end
    end
  end

  // Response monitor: pops an expectation for every done pulse.
  logic [W-1:0] got_e;
  always @(negedge clk) begin
    if (resetn) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          got_e = exp_q.pop_front();
          check("done_cycle", 32'(cyc[15:0]), 32'(got_e[21:6]));
          check("done_id", done_id, got_e[5]);
          check("done_err", err, got_e[4]);
          check("final_count", count, got_e[3:0]);
        end
      end else begin
        check("err_idle", err, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a command on the requesters in mask and holds it until each is accepted.
  task automatic send(input logic [1:0] mask, input logic [3:0] op,
                      input logic [7:0] arg, input logic [1:0] dir);
    logic [1:0] pending, acc;
    int t;
    req_op    = op;
    req_arg   = arg;
    req_dir   = dir;
    pending   = mask;
    req_valid = mask;
    t = 0;
    while (pending != 2'b00 && t < 300) begin
      @(negedge clk);
      acc = req_ready & pending;
      @(posedge clk); #1;
      pending   = pending & ~acc;
      req_valid = pending;
      t++;
    end
    if (pending != 2'b00) begin
      check("accept_timeout", 1, 0);
      req_valid = 2'b00;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 300);
    if (busy) check("idle_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle_cycles(3);
    resetn = 1'b1;
    idle_cycles(1);

    // A: LOAD 7, then the value is held.
    send(2'b01, 4'b0000, 8'h07, 2'b00);
    wait_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold7", count, 7);
    end
    idle_cycles(1);

    // A: STEP 4 up from 10, wrapping through 0.
    send(2'b01, 4'b0000, 8'h0A, 2'b00);
    send(2'b01, 4'b0001, 8'h04, 2'b00);
    wait_idle();

    // B: SEEK 10 from 1 goes the short way down.
    send(2'b10, 4'b0000, 8'h10, 2'b00);
    send(2'b10, 4'b1000, 8'hA0, 2'b00);
    wait_idle();

    // Tie distance goes up; clamped SEEK and LOAD flag err.
    send(2'b01, 4'b0000, 8'h05, 2'b00);
    send(2'b01, 4'b0010, 8'h0B, 2'b00);
    send(2'b01, 4'b0000, 8'h05, 2'b00);
    send(2'b01, 4'b0010, 8'h0E, 2'b00);
    send(2'b01, 4'b0000, 8'h0D, 2'b00);
    wait_idle();

    // Three ties in a row alternate between requesters.
    send(2'b10, 4'b0000, 8'h40, 2'b00);
    for (int i = 0; i < 3; i++) send(2'b11, 4'b0000, 8'h92, 2'b00);
    wait_idle();

    // Reset in the middle of a STEP 9 aborts it with no done pulse.
    send(2'b01, 4'b0000, 8'h03, 2'b00);
    send(2'b01, 4'b0001, 8'h09, 2'b00);
    idle_cycles(3);
    resetn = 1'b0;
    idle_cycles(1);
    resetn = 1'b1;
    @(negedge clk);
    check("after_reset_count", count, 0);
    check("after_reset_busy", busy, 0);
    idle_cycles(1);

    // Zero-length STEP and the reserved opcode finish immediately.
    send(2'b01, 4'b0001, 8'h00, 2'b00);
    send(2'b10, 4'b1100, 8'h50, 2'b00);
    wait_idle();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      send(2'($urandom_range(1, 3)), 4'($urandom), 8'($urandom), 2'($urandom));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    idle_cycles(3);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
